jtbubl_gfx_romslot: RTL and testbench
=====================================

Name: jtbubl_gfx_romslot

Overview:
- SDRAM-side responder for the object/tile renderer's ROM request port (rom_cs / rom_addr / rom_data / rom_ok).
- Converts each 32-bit pixel-row fetch into a two-word (16-bit) SDRAM burst, assembles the result and presents it with rom_ok.
- Holds a one-entry cache of the last fetched row, so repeated requests to the same address are answered without SDRAM traffic.
- Sits between jtbubl_gfx and the SDRAM arbiter.

Parameters:
- AW, 18, width of rom_addr in 16-bit words.
- OFFSET, 22'h0, SDRAM word offset of the graphics region, added to the request address.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- downloading  in  1  ROM load in progress; blocks requests and invalidates the cache.
- rom_cs  in  1  renderer request strobe, level-held while it needs data.
- rom_addr  in  AW  word address; bit 0 is ignored (32-bit alignment).
- rom_data  out  32  assembled row; first word in [15:0], second word in [31:16].
- rom_ok  out  1  rom_data is valid for the current rom_addr.
- sd_addr  out  22  SDRAM word address of the burst.
- sd_req  out  1  burst request, held until acknowledged.
- sd_ack  in  1  one-cycle pulse: arbiter accepted the request.
- sd_rdy  in  1  one-cycle pulse per delivered 16-bit word.
- sd_din  in  16  SDRAM read data, valid when sd_rdy is high.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state=IDLE, sd_req=0, sd_addr=0, rom_data=0, cache valid=0, cached address=0.
  - rom_ok is therefore 0.
- Cache hit, combinational from registered state:
  - hit = valid & (rom_addr[AW-1:1] == cached_addr[AW-1:1]).
  - rom_ok = rom_cs & hit & ~downloading.
  - A new address is never flagged ok on the cycle it appears unless it truly matches the cached row.
- rom_data always reflects the cached row; it changes only when a burst completes.
- State machine:
  - IDLE: if rom_cs & ~hit & ~downloading, latch req_addr = rom_addr with bit 0 forced to 0, drive sd_addr = OFFSET + req_addr (22-bit, wraps modulo 2^22), set sd_req=1, go to REQ.
  - REQ: hold sd_req and sd_addr stable. On sd_ack, clear sd_req and go to W0. If sd_ack and sd_rdy arrive in the same cycle, accept both and go to W1.
  - W0: on sd_rdy, store sd_din into a low holding register, go to W1.
  - W1: on sd_rdy, rom_data <= {sd_din, low}, cached_addr <= req_addr, valid <= 1, go to IDLE.
- Latency:
  - The earliest miss-to-ok time is 1 (issue) + ack + 2 word cycles.
  - rom_ok rises on the cycle after the second sd_rdy, provided rom_addr still matches.
- Changes on the renderer side while a burst is in flight:
  - A rom_addr change or rom_cs drop during REQ/W0/W1 does not abort the burst.
  - The burst completes and is cached under req_addr; a new miss is evaluated back in IDLE.
- Cache validity during a burst:
  - valid stays 1 until W1 completes, so the old row remains servable.
  - Exception: downloading clears valid immediately.
- downloading high:
  - valid <= 0 every cycle.
  - In REQ, sd_req drops and the block returns to IDLE with no burst issued.
  - In W0/W1, the block finishes receiving the words but does not set valid.
- sd_rdy in IDLE or REQ without ack: ignored.
- sd_ack outside REQ: ignored.
- rst mid-burst: returns to IDLE at once. Late sd_rdy pulses are then ignored, because IDLE ignores sd_rdy.
- No new request issues in the same cycle a burst completes. IDLE evaluates on the following cycle, using the updated cache.

Test Plan:
- Miss then hit:
  - Stimulus: after reset, rom_cs=1, rom_addr=18'h00124. Arbiter acks 2 cycles later, then sd_din=16'hBEEF, 16'hDEAD on consecutive cycles.
  - Required: sd_addr=22'h000124, sd_req drops on ack, then rom_data=32'hDEADBEEF with rom_ok=1. A repeated request issues no new sd_req.
- Alignment:
  - Stimulus: cached 18'h00124, then request 18'h00125.
  - Required: rom_ok=1 immediately, no burst.
- Offset and wrap:
  - Stimulus: OFFSET=22'h3FFFF0, rom_addr=18'h00020.
  - Required: sd_addr=22'h000010.
- Address change mid-burst:
  - Stimulus: request 18'h00200, then switch to 18'h00300 during W0.
  - Required: rom_ok stays 0. The first burst caches 18'h00200, then a second sd_req issues for 18'h00300, and rom_ok rises only after its second word.
- downloading during REQ:
  - Stimulus: assert downloading while sd_req=1.
  - Required: sd_req=0 next cycle, state IDLE, valid=0, rom_ok=0 for the previously cached address.
- Reset mid-burst:
  - Stimulus: rst pulse in W1, followed by a stray sd_rdy.
  - Required: rom_ok=0, rom_data=0, sd_req=0, and no cache update.

Source files
------------

// File: rtl/jtbubl_gfx_romslot_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : jtbubl_gfx_romslot_if                                   |
// | Description : Renderer ROM port plus SDRAM arbiter port bundle for    |
// |               the graphics ROM slot.                                  |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface jtbubl_gfx_romslot_if #(
    parameter int AW = 18
);
    logic          downloading;
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data;
    logic          rom_ok;
    logic [21:0]   sd_addr;
    logic          sd_req;
    logic          sd_ack;
    logic          sd_rdy;
    logic [15:0]   sd_din;

    // Environment side: renderer plus SDRAM arbiter.
    modport master (
        output downloading, rom_cs, rom_addr, sd_ack, sd_rdy, sd_din,
        input  rom_data, rom_ok, sd_addr, sd_req
    );

    // ROM slot side.
    modport slave (
        input  downloading, rom_cs, rom_addr, sd_ack, sd_rdy, sd_din,
        output rom_data, rom_ok, sd_addr, sd_req
    );
endinterface
`default_nettype wire

// File: rtl/jtbubl_gfx_romslot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : jtbubl_gfx_romslot                                      |
// | Description : Serves 32-bit renderer row fetches from SDRAM as        |
// |               two-word bursts, with a one-entry row cache.            |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module jtbubl_gfx_romslot #(
    parameter int          AW     = 18,
    parameter logic [21:0] OFFSET = 22'h0
) (
    input wire clk,
    input wire rst,
    jtbubl_gfx_romslot_if.slave bus
);
    // Rows are 32 bits wide, so the word address LSB never selects anything.
    localparam logic [AW-1:0] c_align_mask = {{(AW-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_W0   = 2'd2,
        ST_W1   = 2'd3
    } state_t;

    state_t        r_state,       w_state_nxt;
    logic          r_sd_req,      w_sd_req_nxt;
    logic [21:0]   r_sd_addr,     w_sd_addr_nxt;
    logic [AW-1:0] r_req_addr,    w_req_addr_nxt;
    logic [AW-1:0] r_cached_addr, w_cached_addr_nxt;
    logic          r_valid,       w_valid_nxt;
    logic [15:0]   r_low,         w_low_nxt;
    logic [31:0]   r_rom_data,    w_rom_data_nxt;

    logic [AW-1:0] w_addr_aligned;
    logic          w_hit;

    // Both sides of the compare carry a zero LSB, so a full-width compare
    // is a row compare.
    assign w_addr_aligned = bus.rom_addr & c_align_mask;
    assign w_hit          = r_valid && (w_addr_aligned == r_cached_addr);

    assign bus.rom_ok   = bus.rom_cs & w_hit & ~bus.downloading;
    assign bus.rom_data = r_rom_data;
    assign bus.sd_req   = r_sd_req;
    assign bus.sd_addr  = r_sd_addr;

    // Next-state and datapath updates for the burst sequencer.
    always_comb begin
        w_state_nxt       = r_state;
        w_sd_req_nxt      = r_sd_req;
        w_sd_addr_nxt     = r_sd_addr;
        w_req_addr_nxt    = r_req_addr;
        w_cached_addr_nxt = r_cached_addr;
        w_valid_nxt       = r_valid;
        w_low_nxt         = r_low;
        w_rom_data_nxt    = r_rom_data;

        case (r_state)
            ST_IDLE: begin
                if (bus.rom_cs && !w_hit && !bus.downloading) begin
                    w_req_addr_nxt = w_addr_aligned;
                    w_sd_addr_nxt  = OFFSET + 22'(w_addr_aligned);
                    w_sd_req_nxt   = 1'b1;
                    w_state_nxt    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.downloading) begin
                    // Withdraw the request; the ROM contents are changing.
                    w_sd_req_nxt = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end else if (bus.sd_ack) begin
                    w_sd_req_nxt = 1'b0;
                    if (bus.sd_rdy) begin
                        // Arbiter may deliver the first word with the ack.
                        w_low_nxt   = bus.sd_din;
                        w_state_nxt = ST_W1;
                    end else begin
                        w_state_nxt = ST_W0;
                    end
                end
            end
            ST_W0: begin
                if (bus.sd_rdy) begin
                    w_low_nxt   = bus.sd_din;
                    w_state_nxt = ST_W1;
                end
            end
            ST_W1: begin
                if (bus.sd_rdy) begin
                    w_rom_data_nxt    = {bus.sd_din, r_low};
                    w_cached_addr_nxt = r_req_addr;
                    w_valid_nxt       = 1'b1;
                    w_state_nxt       = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A ROM download invalidates the cache regardless of burst progress.
        if (bus.downloading) begin
            w_valid_nxt = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_sd_req      <= 1'b0;
            r_sd_addr     <= '0;
            r_req_addr    <= '0;
            r_cached_addr <= '0;
            r_valid       <= 1'b0;
            r_low         <= '0;
            r_rom_data    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_sd_req      <= w_sd_req_nxt;
            r_sd_addr     <= w_sd_addr_nxt;
            r_req_addr    <= w_req_addr_nxt;
            r_cached_addr <= w_cached_addr_nxt;
            r_valid       <= w_valid_nxt;
            r_low         <= w_low_nxt;
            r_rom_data    <= w_rom_data_nxt;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_jtbubl_gfx_romslot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_jtbubl_gfx_romslot                                   |
// | Description : Scoreboard bench for the graphics ROM slot with a       |
// |               randomized arbiter responder and a row-cache model.     |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_jtbubl_gfx_romslot;
    localparam logic [21:0] c_off  = 22'h0;
    localparam logic [21:0] c_off2 = 22'h3FFFF0;

    typedef struct {
        logic [31:0] data;
        bit          imm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    jtbubl_gfx_romslot_if #(.AW(18)) bus ();
    jtbubl_gfx_romslot_if #(.AW(18)) bus2 ();

    jtbubl_gfx_romslot #(.AW(18), .OFFSET(c_off)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    jtbubl_gfx_romslot #(.AW(18), .OFFSET(c_off2)) dut_off (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int total = 0;
    int bad   = 0;

    exp_t        rdq[$];
    logic [21:0] sdq[$];

    // Reference cache model: which row is held and its data.
    bit          ref_valid = 1'b0;
    logic [16:0] ref_row   = '0;
    logic [31:0] ref_data  = '0;

    // Arbiter responder controls.
    bit resp_en  = 1'b1;
    bit fixed    = 1'b0;
    int fx_d     = 0;
    int fx_gap1  = 0;
    int done_cyc = -10;
    int issue_cyc = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // SDRAM contents as a pure function of the word address.
    function automatic logic [15:0] mem_rd(input logic [21:0] a);
        if (a == 22'h000124) return 16'hBEEF;
        if (a == 22'h000125) return 16'hDEAD;
        return a[15:0] ^ {a[21:16], a[9:0]} ^ 16'h5A3C;
    endfunction

    function automatic logic [21:0] sd_of(input logic [21:0] off, input logic [17:0] a);
        int unsigned s;
        s = int'(off) + int'({a[17:1], 1'b0});
        return 22'(s % 32'h400000);
    endfunction

    function automatic logic [31:0] row_data(input logic [17:0] a);
        logic [21:0] s;
        s = sd_of(c_off, a);
        return {mem_rd(22'(s + 22'd1)), mem_rd(s)};
    endfunction

    // Arbiter model: acks a pending request and streams two words.
    initial begin : responder
        logic [21:0] a;
        int d;
        int gap;
        bit comb;
        bus.sd_ack = 1'b0;
        bus.sd_rdy = 1'b0;
        bus.sd_din = '0;
        forever begin
            @(negedge clk);
            if (!(bus.sd_req && resp_en && !rst)) continue;
            a = bus.sd_addr;
            d = fixed ? fx_d : int'($urandom_range(0, 2));
            repeat (d) @(negedge clk);
            if (!bus.sd_req) continue;
            comb = fixed ? 1'b0 : ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            bus.sd_ack = 1'b1;
            bus.sd_rdy = comb;
            bus.sd_din = comb ? mem_rd(a) : 16'h0;
            for (int w = (comb ? 1 : 0); w < 2; w++) begin
                gap = fixed ? ((w == 1) ? fx_gap1 : 0) : int'($urandom_range(0, 2));
                repeat (gap) begin
                    @(posedge clk); #1;
                    bus.sd_ack = 1'b0;
                    bus.sd_rdy = 1'b0;
                end
                @(posedge clk); #1;
                bus.sd_ack = 1'b0;
                bus.sd_rdy = 1'b1;
                bus.sd_din = mem_rd(22'(a + 22'(w)));
                if (w == 1) done_cyc = cyc;
            end
            @(posedge clk); #1;
            bus.sd_ack = 1'b0;
            bus.sd_rdy = 1'b0;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request or a row.
    initial begin : monitor
        bit   prev_req = 1'b0;
        bit   prev_ok  = 1'b0;
        bit   prev_ack = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (prev_ack) chk("req_drop_on_ack", 32'(bus.sd_req), 32'd0);
            if (bus.sd_req && !prev_req) begin
                if (sdq.size() == 0) chk("unexpected_sd_req", 32'(bus.sd_addr), 32'hFFFFFFFF);
                else chk("sd_addr", 32'(bus.sd_addr), 32'(sdq.pop_front()));
            end
            if (bus.rom_ok && !prev_ok) begin
                if (rdq.size() == 0) begin
                    chk("unexpected_rom_ok", bus.rom_data, 32'hFFFFFFFF);
                end else begin
                    e = rdq.pop_front();
                    chk("rom_data", bus.rom_data, e.data);
                    if (e.imm) chk("hit_latency", 32'(cyc), 32'(issue_cyc));
                    else       chk("miss_latency", 32'(cyc), 32'(done_cyc + 1));
                end
            end
            prev_req = bus.sd_req;
            prev_ok  = bus.rom_ok;
            prev_ack = bus.sd_ack;
        end
    end

    task automatic wait_resp();
        for (int i = 0; i < 80 && rdq.size() != 0; i++) begin
            @(negedge clk); #2;
        end
        chk("resp_timeout", 32'(rdq.size()), 32'd0);
        rdq.delete();
    endtask

    // One renderer fetch: predict, drive, wait for the row, release rom_cs.
    task automatic fetch(input logic [17:0] a);
        exp_t e;
        bit   hit;
        hit    = ref_valid && (ref_row == a[17:1]);
        e.data = hit ? ref_data : row_data(a);
        e.imm  = hit;
        if (!hit) sdq.push_back(sd_of(c_off, a));
        rdq.push_back(e);
        ref_valid = 1'b1;
        ref_row   = a[17:1];
        ref_data  = e.data;
        @(posedge clk); #1;
        bus.rom_cs   = 1'b1;
        bus.rom_addr = a;
        issue_cyc    = cyc;
        if (!hit) begin
            @(negedge clk);
            chk("miss_not_ok_at_issue", 32'(bus.rom_ok), 32'd0);
        end
        wait_resp();
        @(posedge clk); #1;
        bus.rom_cs = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [17:0] pool[6];
        logic [17:0] x;
        logic [17:0] y;
        bus.downloading  = 1'b0;
        bus.rom_cs       = 1'b0;
        bus.rom_addr     = '0;
        bus2.downloading = 1'b0;
        bus2.rom_cs      = 1'b0;
        bus2.rom_addr    = '0;
        bus2.sd_ack      = 1'b0;
        bus2.sd_rdy      = 1'b0;
        bus2.sd_din      = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("reset_rom_ok",   32'(bus.rom_ok),  32'd0);
        chk("reset_rom_data", bus.rom_data,     32'd0);
        chk("reset_sd_req",   32'(bus.sd_req),  32'd0);
        chk("reset_sd_addr",  32'(bus.sd_addr), 32'd0);

        // Miss then hit, with a fixed arbiter timing.
        fixed = 1'b1; fx_d = 1; fx_gap1 = 0;
        fetch(18'h00124);
        chk("first_row", ref_data, 32'hDEADBEEF);
        fetch(18'h00124);
        // Odd word address within the cached row.
        fetch(18'h00125);
        fixed = 1'b0;

        // Offset addition wraps modulo 2^22.
        @(posedge clk); #1;
        bus2.rom_cs   = 1'b1;
        bus2.rom_addr = 18'h00020;
        @(negedge clk);
        @(negedge clk);
        chk("offset_sd_req",  32'(bus2.sd_req),  32'd1);
        chk("offset_sd_addr", 32'(bus2.sd_addr), 32'(sd_of(c_off2, 18'h00020)));

        // Address change while the burst is in flight.
        sdq.push_back(sd_of(c_off, 18'h00200));
        sdq.push_back(sd_of(c_off, 18'h00300));
        rdq.push_back('{data: row_data(18'h00300), imm: 1'b0});
        @(posedge clk); #1;
        bus.rom_cs   = 1'b1;
        bus.rom_addr = 18'h00200;
        for (int i = 0; i < 20 && !bus.sd_ack; i++) @(negedge clk);
        chk("chg_ack_seen", 32'(bus.sd_ack), 32'd1);
        @(posedge clk); #1;
        bus.rom_addr = 18'h00300;
        wait_resp();
        ref_valid = 1'b1;
        ref_row   = 17'h00180;
        ref_data  = row_data(18'h00300);
        @(posedge clk); #1;
        bus.rom_cs = 1'b0;

        // Randomized fetches over a small pool so hits and misses mix.
        foreach (pool[k]) pool[k] = 18'($urandom_range(0, 32'h3FFFF));
        for (int n = 0; n < 40; n++) begin
            fetch(pool[$urandom_range(0, 5)] ^ 18'($urandom_range(0, 1)));
        end

        // Download during REQ withdraws the request and invalidates.
        x = {ref_row, 1'b0};
        y = {ref_row ^ 17'h1, 1'b0};
        resp_en = 1'b0;
        sdq.push_back(sd_of(c_off, y));
        @(posedge clk); #1;
        bus.rom_cs   = 1'b1;
        bus.rom_addr = y;
        for (int i = 0; i < 10 && !bus.sd_req; i++) @(negedge clk);
        chk("dl_req_issued", 32'(bus.sd_req), 32'd1);
        @(posedge clk); #1;
        bus.downloading = 1'b1;
        bus.rom_addr    = x;
        @(negedge clk);
        chk("dl_rom_ok", 32'(bus.rom_ok), 32'd0);
        @(negedge clk);
        chk("dl_sd_req_drop", 32'(bus.sd_req), 32'd0);
        @(posedge clk); #1;
        bus.downloading = 1'b0;
        bus.rom_cs      = 1'b0;
        ref_valid = 1'b0;
        resp_en   = 1'b1;
        fetch(x);

        // Reset in W1 followed by a stray word.
        y = {ref_row ^ 17'h2, 1'b0};
        fixed = 1'b1; fx_d = 0; fx_gap1 = 2;
        sdq.push_back(sd_of(c_off, y));
        @(posedge clk); #1;
        bus.rom_cs   = 1'b1;
        bus.rom_addr = y;
        for (int i = 0; i < 20 && !bus.sd_rdy; i++) @(negedge clk);
        chk("rst_first_word_seen", 32'(bus.sd_rdy), 32'd1);
        @(posedge clk); #1;
        rst        = 1'b1;
        bus.rom_cs = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_rom_data", bus.rom_data,    32'd0);
        chk("rst_mid_sd_req",   32'(bus.sd_req), 32'd0);
        repeat (4) @(negedge clk);
        chk("rst_stray_no_update", bus.rom_data, 32'd0);
        fixed     = 1'b0;
        ref_valid = 1'b0;
        fetch(y);
        fetch(y);

        repeat (5) @(negedge clk);
        chk("sd_req_missing", 32'(sdq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
